// File: rtl/imem_line_responder_if.sv
// Bundles the fetch-side imem request port and the backing-memory burst read port
// so the responder and its surroundings share one connection.
interface imem_line_responder_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_inval;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic        bmem_rvalid;
  logic [63:0] bmem_rdata;

  // Fetch stage plus backing memory: drives requests and burst beats.
  modport master (
    output imem_addr, imem_rmask, imem_inval, bmem_ready, bmem_rvalid, bmem_rdata,
    input  imem_rdata, imem_resp, bmem_addr, bmem_read
  );

  // Responder side.
  modport slave (
    input  imem_addr, imem_rmask, imem_inval, bmem_ready, bmem_rvalid, bmem_rdata,
    output imem_rdata, imem_resp, bmem_addr, bmem_read
  );
endinterface

// File: rtl/imem_line_responder.sv
// Single-line instruction buffer: hits answer next cycle, misses burst-fill 4x64-bit beats.
// Optional macro IMEM_CRITICAL_WORD_BYPASS_EN answers as soon as the requested beat lands.
module imem_line_responder #(
  parameter int LINE_BEATS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_line_responder_if.slave bus
);
  localparam int LINE_W = 64 * LINE_BEATS;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL} state_t;

  state_t              state, state_nxt;
  logic                resp_q, resp_nxt;
  logic [31:0]         rdata_q, rdata_nxt;
  logic                read_q, read_nxt;
  logic [31:0]         baddr_q, baddr_nxt;
  logic                line_valid, line_valid_nxt;
  logic                kill_q, kill_nxt;
  logic [1:0]          beat_cnt, beat_cnt_nxt;
  logic [31:2]         req_addr;
  logic [31:5]         line_tag;
  logic [LINE_W-1:0]   line_data, fill_line;
  logic                req_seen, hit, beat_we, last_beat;
  logic                unused_addr_bits;

  function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line, input logic [2:0] idx);
    return line[32*idx +: 32];
  endfunction

  assign unused_addr_bits = ^bus.imem_addr[1:0];

  assign bus.imem_resp  = resp_q;
  assign bus.imem_rdata = rdata_q;
  assign bus.bmem_read  = read_q;
  assign bus.bmem_addr  = baddr_q;

  assign req_seen  = (state == IDLE) && (bus.imem_rmask != 4'd0);
  assign hit       = line_valid && (line_tag == bus.imem_addr[31:5]) && !bus.imem_inval;
  assign beat_we   = (state == MISS_FILL) && bus.bmem_rvalid;
  assign last_beat = beat_we && (beat_cnt == 2'(LINE_BEATS - 1));

  // Line as it will look after this cycle's beat, so the final word can be answered from it.
  always_comb begin
    fill_line = line_data;
    if (beat_we) fill_line[64*beat_cnt +: 64] = bus.bmem_rdata;
  end

  always_comb begin
    state_nxt      = state;
    resp_nxt       = 1'b0;
    rdata_nxt      = rdata_q;
    read_nxt       = read_q;
    baddr_nxt      = baddr_q;
    line_valid_nxt = line_valid;
    kill_nxt       = kill_q;
    beat_cnt_nxt   = beat_cnt;

    if (state != IDLE && bus.imem_inval) kill_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (req_seen) begin
          if (hit) begin
            resp_nxt  = 1'b1;
            rdata_nxt = pick_word(line_data, bus.imem_addr[4:2]);
          end else begin
            state_nxt      = MISS_REQ;
            read_nxt       = 1'b1;
            baddr_nxt      = {bus.imem_addr[31:5], 5'b0};
            line_valid_nxt = 1'b0;
            kill_nxt       = 1'b0;
          end
        end
      end
      MISS_REQ: begin
        if (bus.bmem_ready) begin
          read_nxt     = 1'b0;
          beat_cnt_nxt = 2'd0;
          state_nxt    = MISS_FILL;
        end
      end
      MISS_FILL: begin
        if (beat_we) begin
          beat_cnt_nxt = beat_cnt + 2'd1;
`ifdef IMEM_CRITICAL_WORD_BYPASS_EN
          if (beat_cnt == req_addr[4:3]) begin
            resp_nxt  = 1'b1;
            rdata_nxt = pick_word(fill_line, req_addr[4:2]);
          end
`else
          if (last_beat) begin
            resp_nxt  = 1'b1;
            rdata_nxt = pick_word(fill_line, req_addr[4:2]);
          end
`endif
          if (last_beat) begin
            state_nxt      = IDLE;
            line_valid_nxt = !(kill_q || bus.imem_inval);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // An invalidate always wins over any valid update in the same cycle.
    if (bus.imem_inval) line_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_q     <= 1'b0;
      rdata_q    <= 32'd0;
      read_q     <= 1'b0;
      baddr_q    <= 32'd0;
      line_valid <= 1'b0;
      kill_q     <= 1'b0;
      beat_cnt   <= 2'd0;
    end else begin
      state      <= state_nxt;
      resp_q     <= resp_nxt;
      rdata_q    <= rdata_nxt;
      read_q     <= read_nxt;
      baddr_q    <= baddr_nxt;
      line_valid <= line_valid_nxt;
      kill_q     <= kill_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (req_seen)  req_addr  <= bus.imem_addr[31:2];
    if (beat_we)   line_data <= fill_line;
    if (last_beat) line_tag  <= req_addr[31:5];
  end
endmodule

// File: tb/tb_imem_line_responder.sv
// Directed and randomized fetches against a line-level model of the responder.
module tb_imem_line_responder;
  logic clk = 1'b0;
  logic rst_n;
  imem_line_responder_if bus();

  imem_line_responder #(.LINE_BEATS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] key;
  bit          model_valid;
  logic [31:5] model_tag;

`ifdef IMEM_CRITICAL_WORD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B9) ^ key ^ {w[15:0], w[31:16]};
  endfunction

  function automatic logic [63:0] mem_beat(input logic [31:0] a);
    return {mem_word(a + 32'd4), mem_word(a)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_rmask  = 4'd0;
    bus.imem_inval  = 1'b0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b0;
  endtask

  // One request; predicts hit or miss from the resident-line model and drives the burst if needed.
  task automatic fetch(input logic [31:0] addr, input int rdy_dly, input int inval_beat, input bit inval_req);
    bit          hit;
    bit          exp_resp;
    int          resps;
    logic [31:0] base;
    logic [31:0] exp_w;
    hit   = model_valid && (model_tag == addr[31:5]) && !inval_req;
    base  = {addr[31:5], 5'b0};
    exp_w = mem_word(addr);
    bus.imem_addr  = addr;
    bus.imem_rmask = 4'($urandom_range(1, 15));
    bus.imem_inval = inval_req;
    tick();
    bus.imem_rmask = 4'd0;
    bus.imem_inval = 1'b0;
    if (inval_req) model_valid = 1'b0;
    if (hit) begin
      check("hit_resp", bus.imem_resp, 1);
      check("hit_rdata", bus.imem_rdata, exp_w);
      check("hit_no_bmem_read", bus.bmem_read, 0);
      return;
    end
    check("miss_no_resp", bus.imem_resp, 0);
    check("miss_bmem_read", bus.bmem_read, 1);
    check("miss_bmem_addr", bus.bmem_addr, base);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.bmem_rvalid = 1'($urandom_range(0, 1));
      bus.bmem_rdata  = {$urandom, $urandom};
      tick();
      check("wait_bmem_read", bus.bmem_read, 1);
      check("wait_bmem_addr", bus.bmem_addr, base);
      check("wait_no_resp", bus.imem_resp, 0);
    end
    bus.bmem_ready  = 1'b1;
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata  = {$urandom, $urandom};
    tick();
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b0;
    check("accept_read_drop", bus.bmem_read, 0);
    check("accept_no_resp", bus.imem_resp, 0);
    resps = 0;
    for (int b = 0; b < 4; b++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        bus.bmem_rdata = {$urandom, $urandom};
        tick();
        check("gap_no_resp", bus.imem_resp, 0);
      end
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = mem_beat(base + 32'(8 * b));
      bus.imem_inval  = (b == inval_beat);
      tick();
      bus.bmem_rvalid = 1'b0;
      bus.imem_inval  = 1'b0;
      exp_resp = BYPASS ? (b == int'(addr[4:3])) : (b == 3);
      check("fill_resp", bus.imem_resp, exp_resp);
      if (exp_resp) check("fill_rdata", bus.imem_rdata, exp_w);
      if (bus.imem_resp) resps++;
    end
    check("single_resp", resps, 1);
    model_valid = (inval_beat < 0);
    model_tag   = addr[31:5];
    tick();
    check("post_fill_quiet", bus.imem_resp, 0);
    check("rdata_holds", bus.imem_rdata, exp_w);
    check("post_fill_no_read", bus.bmem_read, 0);
  endtask

  initial begin
    key = $urandom;
    model_valid = 1'b0;
    model_tag   = '0;
    bus.imem_addr  = 32'd0;
    bus.bmem_rdata = 64'd0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_resp", bus.imem_resp, 0);
    check("rst_rdata", bus.imem_rdata, 0);
    check("rst_bmem_read", bus.bmem_read, 0);
    check("rst_bmem_addr", bus.bmem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    fetch(32'h0000_1004, 0, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.imem_addr  = 32'h0000_1000 + 32'(4 * i);
      bus.imem_rmask = 4'hF;
      tick();
      check("stream_resp", bus.imem_resp, 1);
      check("stream_rdata", bus.imem_rdata, mem_word(32'h0000_1000 + 32'(4 * i)));
      check("stream_no_read", bus.bmem_read, 0);
    end
    bus.imem_rmask = 4'd0;
    tick();
    check("stream_end_quiet", bus.imem_resp, 0);

    fetch(32'h0000_2000, 1, -1, 1'b0);
    fetch(32'h0000_1000, 0, -1, 1'b0);
    fetch(32'h0000_3000, 0, 2, 1'b0);
    fetch(32'h0000_3000, 0, -1, 1'b0);
    fetch(32'h0000_3004, 0, -1, 1'b0);
    fetch(32'h0000_601C, 5, -1, 1'b0);

    // Reset in the middle of a fill, then stray beats.
    bus.imem_addr  = 32'h0000_5008;
    bus.imem_rmask = 4'hF;
    tick();
    bus.imem_rmask = 4'd0;
    bus.bmem_ready = 1'b1;
    tick();
    bus.bmem_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = mem_beat(32'h0000_5000 + 32'(8 * b));
      tick();
    end
    bus.bmem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midfill_rst_resp", bus.imem_resp, 0);
    check("midfill_rst_rdata", bus.imem_rdata, 0);
    check("midfill_rst_read", bus.bmem_read, 0);
    check("midfill_rst_addr", bus.bmem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = {$urandom, $urandom};
      tick();
      check("stray_no_resp", bus.imem_resp, 0);
      check("stray_no_read", bus.bmem_read, 0);
    end
    bus.bmem_rvalid = 1'b0;
    fetch(32'h0000_5008, 0, -1, 1'b0);

    fetch(32'h0000_4014, 0, -1, 1'b0);
    fetch(32'h0000_4000, 0, -1, 1'b0);
    bus.imem_inval = 1'b1;
    tick();
    bus.imem_inval = 1'b0;
    model_valid = 1'b0;
    fetch(32'h0000_4000, 0, -1, 1'b0);
    fetch(32'h0000_4008, 0, -1, 1'b1);
    fetch(32'h0000_400C, 0, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          ib;
      case ($urandom_range(0, 3))
        0:       a = 32'h0000_7000;
        1:       a = 32'h0000_7020;
        2:       a = 32'h8000_7000;
        default: a = 32'h0000_7040;
      endcase
      a  = a + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      ib = ($urandom_range(0, 7) < 2) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, int'($urandom_range(0, 4)), ib, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
